stepper_ctrl: RTL



---
 rtl/stepper_pkg.sv | 35 +++
 rtl/bcd_updown_counter.sv | 51 +++++
 rtl/stepper_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper controller:
// coil sequence table, drive modes and the index step-size helper.
package stepper_pkg;

    typedef enum logic [1:0] {
        MODE_WAVE = 2'b00,
        MODE_FULL = 2'b01,
        MODE_HALF = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    // Entry 0 sits in the low nibble; coil order is {A,B,C,D}.
    localparam logic [7:0][3:0] COIL_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    // Wave lives on even indices and full on odd ones;
    // a single step realigns an index that is off-grid.
    function automatic logic [2:0] step_size(
        input mode_e      mode,
        input logic [2:0] idx
    );
        logic [2:0] s;
        s = 3'd0;
        unique case (mode)
            MODE_HALF: s = 3'd1;
            MODE_WAVE: s = idx[0] ? 3'd1 : 3'd2;
            MODE_FULL: s = idx[0] ? 3'd2 : 3'd1;
            MODE_OFF:  s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with ripple carry/borrow;
// wraps all-9 -> all-0 going up and all-0 -> all-9 going down.
module bcd_updown_counter #(
    parameter int N_DIGITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_inc,
    input  logic                  i_dec,
    output logic [4*N_DIGITS-1:0] o_digits
);

    logic [N_DIGITS-1:0][3:0] dig_q;
    logic [N_DIGITS-1:0][3:0] dig_d;

    always_comb begin
        logic cy;
        logic bw;
        dig_d = dig_q;
        cy    = i_inc & ~i_dec;
        bw    = i_dec & ~i_inc;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cy) begin
                if (dig_q[i] == 4'd9) begin
                    dig_d[i] = 4'd0;
                end else begin
                    dig_d[i] = dig_q[i] + 4'd1;
                    cy       = 1'b0;
                end
            end else if (bw) begin
                if (dig_q[i] == 4'd0) begin
                    dig_d[i] = 4'd9;
                end else begin
                    dig_d[i] = dig_q[i] - 4'd1;
                    bw       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

    assign o_digits = dig_q;

endmodule

// File: rtl/stepper_ctrl.sv
// 4-coil stepper controller: rate-limited wave/full/half stepping
// from level requests, with a BCD position counter.
module stepper_ctrl
    import stepper_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int N_DIGITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_u,
    input  logic                  i_d,
    input  logic [1:0]            i_mode,
    output logic [2:0]            r_state,
    output logic [3:0]            o_cv,
    output logic [4*N_DIGITS-1:0] o_digits,
    output logic                  o_step,
    output logic                  o_dir
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    mode_e         mode;
    logic          up, dn, act, flip, tick;
    logic [2:0]    size;
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    state_q, state_d;
    logic          dir_q, dir_d;
    logic          step_q;
    logic          prev_up_q, prev_dn_q;

    assign mode = mode_e'(i_mode);

    always_comb begin
        up   = i_u & ~i_d;
        dn   = i_d & ~i_u;
        act  = (up | dn) & (mode != MODE_OFF);
        // A direct u<->d swap restarts the rate interval.
        flip = (up & prev_dn_q) | (dn & prev_up_q);
        tick = act & ~flip & (pre_q == PRE_MAX);

        pre_d   = (!act || flip || tick) ? '0 : pre_q + 1'b1;
        size    = step_size(mode, state_q);
        state_d = state_q;
        dir_d   = dir_q;
        if (tick) begin
            state_d = up ? state_q + size : state_q - size;
            dir_d   = up;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_q     <= '0;
            state_q   <= 3'd0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            prev_up_q <= 1'b0;
            prev_dn_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            step_q    <= tick;
            prev_up_q <= up;
            prev_dn_q <= dn;
        end
    end

    bcd_updown_counter #(
        .N_DIGITS(N_DIGITS)
    ) u_pos (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (tick & up),
        .i_dec   (tick & dn),
        .o_digits(o_digits)
    );

    assign r_state = state_q;
    assign o_cv    = (mode == MODE_OFF) ? 4'b0000 : COIL_TABLE[state_q];
    assign o_step  = step_q;
    assign o_dir   = dir_q;

endmodule
